alu_seq_unit: RTL and testbench

Width-parametrised, handshaked successor to the combinational ALU. It keeps the 16-bit opcode encoding and adds several things:
- a registered flag register (PSR) with explicit carry-in for ADDC;
- signed-direction register shifts;
- an iterative multiplier;
- valid/ready flow control on both sides.

It sits between the decode/register-read stage and writeback. `Flags` is the architectural PSR consumed by branch logic.

---
 rtl/alu_pkg.sv | 93 +++++++++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_seq_unit.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, PSR bit indices, FSM state type and the
// opcode-to-operation decode used by alu_seq_unit.
package alu_pkg;

  localparam int unsigned OP_W    = 16;
  localparam int unsigned FLAGS_W = 6;

  // PSR bit positions
  localparam int unsigned C_BIT = 0;
  localparam int unsigned L_BIT = 1;
  localparam int unsigned F_BIT = 2;
  localparam int unsigned Z_BIT = 3;
  localparam int unsigned N_BIT = 4;
  localparam int unsigned I_BIT = 5;

  // Major opcodes, OpCode[15:12]
  localparam logic [3:0] MAJ_RTYPE = 4'h0;
  localparam logic [3:0] MAJ_ADDI  = 4'h5;
  localparam logic [3:0] MAJ_SHIFT = 4'h8;
  localparam logic [3:0] MAJ_SUBI  = 4'h9;
  localparam logic [3:0] MAJ_CMPI  = 4'hB;

  // Register-register ext codes, OpCode[7:4]
  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_ADDC = 4'h7;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MUL  = 4'hE;

  // Shift ext codes, OpCode[7:4] under MAJ_SHIFT
  localparam logic [3:0] SH_LSHI_L  = 4'h0;
  localparam logic [3:0] SH_LSHI_R  = 4'h1;
  localparam logic [3:0] SH_ASHUI_L = 4'h2;
  localparam logic [3:0] SH_ASHUI_R = 4'h3;
  localparam logic [3:0] SH_LSH     = 4'h4;
  localparam logic [3:0] SH_ASHU    = 4'h6;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  typedef enum logic [3:0] {
    K_ADD,
    K_ADDC,
    K_SUB,
    K_CMP,
    K_AND,
    K_OR,
    K_XOR,
    K_SHIFT,
    K_MUL,
    K_INV
  } op_kind_t;

  // Collapse major/ext into one operation kind; anything unlisted is invalid
  function automatic op_kind_t decode_op(input logic [3:0] major,
                                         input logic [3:0] ext,
                                         input logic       mul_en);
    op_kind_t k;
    k = K_INV;
    case (major)
      MAJ_RTYPE: begin
        case (ext)
          EXT_ADD:  k = K_ADD;
          EXT_ADDC: k = K_ADDC;
          EXT_AND:  k = K_AND;
          EXT_OR:   k = K_OR;
          EXT_XOR:  k = K_XOR;
          EXT_SUB:  k = K_SUB;
          EXT_CMP:  k = K_CMP;
          EXT_MUL:  k = mul_en ? K_MUL : K_INV;
          default:  k = K_INV;
        endcase
      end
      MAJ_ADDI: k = K_ADD;
      MAJ_SUBI: k = K_SUB;
      MAJ_CMPI: k = K_CMP;
      MAJ_SHIFT: begin
        case (ext)
          SH_LSHI_L, SH_LSHI_R, SH_ASHUI_L, SH_ASHUI_R, SH_LSH, SH_ASHU: k = K_SHIFT;
          default: k = K_INV;
        endcase
      end
      default: k = K_INV;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
// Ports: CLK, RESET (sync, active-high); start pulses with operands a/b;
// busy is high for WIDTH cycles; done is high in the last busy cycle, when
// product already holds the full 2*WIDTH-bit result.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [P_W-1:0]   r_acc;
  logic [P_W-1:0]   w_acc_next;

  // Accumulate the shifted multiplicand when the current multiplier bit is set
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_mcand  <= P_W'(a);
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == '0);
  // Final partial product is folded in combinationally so the result is usable at done
  assign product = w_acc_next;

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with registered result C and PSR Flags.
// Ports: CLK, RESET (sync, active-high); in_valid/in_ready accept A, B, OpCode;
// out_valid/out_ready deliver C and Flags; busy is high while MUL iterates.
// Single-cycle ops complete at the accept edge; MUL runs WIDTH extra cycles.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [OP_W-1:0]    OpCode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   C,
  output logic [FLAGS_W-1:0] Flags,
  output logic               busy
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned MSB   = WIDTH - 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_c;
  logic [FLAGS_W-1:0] r_flags;
  logic               r_out_valid;

  logic [3:0]         w_major;
  logic [3:0]         w_ext;
  op_kind_t           w_kind;
  logic [WIDTH-1:0]   w_imm;
  logic [WIDTH-1:0]   w_opnd;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [FLAGS_W-1:0] w_mul_flg;

  logic               w_sh_left;
  logic               w_sh_arith;
  logic               w_sh_neg;
  logic [WIDTH-1:0]   w_sh_mag;
  logic [WIDTH-1:0]   w_sh_res;

  logic               w_cin;
  logic [SUM_W-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic [FLAGS_W-1:0] w_flg;
  logic               w_unused;

  // OpCode[11:8] carries no information for any defined operation
  assign w_unused = ^OpCode[11:8];

  // Decode and operand select: immediate majors use the sign-extended imm8
  assign w_major = OpCode[15:12];
  assign w_ext   = OpCode[7:4];
  assign w_kind  = decode_op(w_major, w_ext, MUL_EN);
  assign w_imm   = WIDTH'($signed(OpCode[7:0]));
  assign w_opnd  = (w_major == MAJ_RTYPE) ? B : w_imm;

  // Handshake: no skid buffer, so a stalled result blocks new work
  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_kind == K_MUL);

  // Shifter: immediate forms use OpCode[3:0]; register forms take signed B
  always_comb begin
    w_sh_neg   = B[MSB];
    w_sh_left  = 1'b1;
    w_sh_arith = 1'b0;
    w_sh_mag   = WIDTH'(OpCode[3:0]);
    case (w_ext)
      SH_LSHI_L, SH_ASHUI_L: w_sh_left = 1'b1;
      SH_LSHI_R: w_sh_left = 1'b0;
      SH_ASHUI_R: begin
        w_sh_left  = 1'b0;
        w_sh_arith = 1'b1;
      end
      SH_LSH, SH_ASHU: begin
        w_sh_left  = !w_sh_neg;
        w_sh_arith = (w_ext == SH_ASHU);
        w_sh_mag   = w_sh_neg ? (~B + WIDTH'(1)) : B;
      end
      default: w_sh_left = 1'b1;
    endcase

    if (w_sh_mag >= WIDTH'(WIDTH)) begin
      // Out-of-range amounts saturate: sign-fill only for arithmetic right
      w_sh_res = (!w_sh_left && w_sh_arith) ? {WIDTH{A[MSB]}} : '0;
    end else if (w_sh_left) begin
      w_sh_res = A << w_sh_mag[SH_W-1:0];
    end else if (w_sh_arith) begin
      w_sh_res = $unsigned($signed(A) >>> w_sh_mag[SH_W-1:0]);
    end else begin
      w_sh_res = A >> w_sh_mag[SH_W-1:0];
    end
  end

  // Single-cycle datapath and flag generation
  always_comb begin
    w_cin  = (w_kind == K_ADDC) ? r_flags[C_BIT] : 1'b0;
    w_sum  = SUM_W'(A) + SUM_W'(w_opnd) + SUM_W'(w_cin);
    w_diff = A - w_opnd;
    w_res  = '0;
    w_flg  = '0;
    case (w_kind)
      K_ADD, K_ADDC: begin
        w_res        = w_sum[MSB:0];
        w_flg[C_BIT] = w_sum[WIDTH];
        w_flg[F_BIT] = (A[MSB] == w_opnd[MSB]) && (w_sum[MSB] != A[MSB]);
      end
      K_SUB: begin
        w_res        = w_diff;
        w_flg[C_BIT] = (A < w_opnd);
        w_flg[F_BIT] = (A[MSB] != w_opnd[MSB]) && (w_diff[MSB] != A[MSB]);
      end
      K_CMP: begin
        w_flg[Z_BIT] = (A == w_opnd);
        w_flg[L_BIT] = (A < w_opnd);
        w_flg[N_BIT] = ($signed(A) < $signed(w_opnd));
      end
      K_AND:   w_res = A & B;
      K_OR:    w_res = A | B;
      K_XOR:   w_res = A ^ B;
      K_SHIFT: w_res = w_sh_res;
      K_INV:   w_flg[I_BIT] = 1'b1;
      default: w_res = '0;
    endcase
    if (!(w_kind inside {K_CMP, K_INV, K_MUL})) begin
      w_flg[Z_BIT] = (w_res == '0);
      w_flg[N_BIT] = w_res[MSB];
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (w_mul_start),
    .a       (A),
    .b       (B),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );

  // MUL flags: F reports a non-zero high half, Z/N come from the low half
  always_comb begin
    w_mul_flg        = '0;
    w_mul_flg[F_BIT] = (w_prod[2*WIDTH-1:WIDTH] != '0);
    w_mul_flg[Z_BIT] = (w_prod[MSB:0] == '0);
    w_mul_flg[N_BIT] = w_prod[MSB];
  end

  // Control FSM with result, PSR and out_valid registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_c         <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_kind == K_MUL) begin
              r_state <= MUL_RUN;
            end else begin
              r_c         <= w_res;
              r_flags     <= w_flg;
              r_out_valid <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          if (w_mul_done) begin
            r_c         <= w_prod[MSB:0];
            r_flags     <= w_mul_flg;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign C         = r_c;
  assign Flags     = r_flags;
  assign busy      = w_mul_busy;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit at WIDTH=16: directed vector table, randomized ops
// against an arithmetic reference model, and handshake/reset sequences.
module tb_alu_seq_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] OpCode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] C;
  logic [5:0]  Flags;
  logic        busy;

  always #5 CLK = ~CLK;

  alu_seq_unit #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OpCode    (OpCode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .Flags     (Flags),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [5:0]  f;
  } vec_t;

  vec_t vecs[20];

  logic [3:0] rt_ext[8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hE};
  logic [3:0] im_maj[3] = '{4'h5, 4'h9, 4'hB};
  logic [3:0] sh_ext[6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: integer arithmetic on the architectural definitions
  function automatic void ref_op(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, output logic [15:0] c, output logic [5:0] f);
    int maj, ext, ua, ub, sa, sb, uo, so, ci, ss, amt, p2;
    longint r;
    logic inv, zn, is_imm, left, arith;
    maj = int'(op[15:12]);
    ext = int'(op[7:4]);
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    is_imm = (maj == 5) || (maj == 9) || (maj == 11);
    so = is_imm ? int'($signed(op[7:0])) : sb;
    uo = so & 32'h0000FFFF;
    r = 0; f = '0; inv = 1'b0; zn = 1'b1;
    if ((maj == 0 && (ext == 5 || ext == 7)) || maj == 5) begin
      ci = (maj == 0 && ext == 7 && cin) ? 1 : 0;
      r = longint'(ua) + uo + ci;
      ss = sa + so + ci;
      f[0] = (r > 65535);
      f[2] = (ss > 32767) || (ss < -32768);
    end else if ((maj == 0 && ext == 9) || maj == 9) begin
      r = longint'(ua) - uo;
      ss = sa - so;
      f[0] = (ua < uo);
      f[2] = (ss > 32767) || (ss < -32768);
    end else if ((maj == 0 && ext == 11) || maj == 11) begin
      f[3] = (ua == uo);
      f[1] = (ua < uo);
      f[4] = (sa < so);
      zn = 1'b0;
    end else if (maj == 0 && ext == 1) begin
      r = longint'(a & b);
    end else if (maj == 0 && ext == 2) begin
      r = longint'(a | b);
    end else if (maj == 0 && ext == 3) begin
      r = longint'(a ^ b);
    end else if (maj == 0 && ext == 14) begin
      r = longint'(ua) * longint'(ub);
      f[2] = (r > 65535);
    end else if (maj == 8 && (ext <= 4 || ext == 6)) begin
      if (ext <= 3) begin
        amt = int'(op[3:0]);
        left = (ext == 0) || (ext == 2);
        arith = (ext == 3);
      end else begin
        left = (sb >= 0);
        amt = left ? sb : -sb;
        arith = (ext == 6);
      end
      if (amt > 16) amt = 16;
      p2 = 1 << amt;
      if (left) r = longint'(ua) * p2;
      else if (!arith) r = ua / p2;
      else r = (sa >= 0) ? sa / p2 : -((-sa + p2 - 1) / p2);
    end else begin
      inv = 1'b1;
    end
    c = r[15:0];
    if (inv) begin
      c = '0;
      f = 6'b100000;
    end else if (zn) begin
      f[3] = (c == 16'h0000);
      f[4] = c[15];
    end
  endfunction

  function automatic logic [15:0] pick_val();
    int v;
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: begin
        v = int'($urandom_range(0, 80)) - 40;
        return 16'(v);
      end
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] pick_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0, 1: return {4'h0, r[11:8], rt_ext[$urandom_range(0, 7)], r[3:0]};
      2: return {im_maj[$urandom_range(0, 2)], r[11:0]};
      3: return {4'h8, r[11:8], sh_ext[$urandom_range(0, 5)], r[3:0]};
      default: return r[15:0];
    endcase
  endfunction

  function automatic bit is_mul(input logic [15:0] op);
    return (op[15:12] == 4'h0) && (op[7:4] == 4'hE);
  endfunction

  // Present one op and wait (bounded) until it is accepted
  task automatic issue(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                       output bit ok);
    ok = 1'b0;
    @(negedge CLK);
    OpCode = op; A = a; B = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge CLK);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // Issue and wait for the result; lat counts edges after the accept edge
  task automatic run_op(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] c, output logic [5:0] f,
                        output int lat, output int busy_n, output bit ok);
    c = '0; f = '0; lat = 0; busy_n = 0;
    issue(op, a, b, ok);
    if (!ok) return;
    while (!out_valid && lat < 40) begin
      if (busy && !in_ready) busy_n++;
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: out_valid stayed 0 for op %h", op);
      ok = 1'b0;
      return;
    end
    c = C;
    f = Flags;
  endtask

  task automatic check_result(input string tag, input logic [15:0] op,
                              input logic [15:0] c, input logic [5:0] f, input int lat, input int busy_n,
                              input logic [15:0] ec, input logic [5:0] ef);
    check($sformatf("%s_C op=%h", tag, op), 32'(c), 32'(ec));
    check($sformatf("%s_Flags op=%h", tag, op), 32'(f), 32'(ef));
    check($sformatf("%s_latency op=%h", tag, op), 32'(lat), is_mul(op) ? 32'd16 : 32'd0);
    if (is_mul(op)) check($sformatf("%s_busy_cycles op=%h", tag, op), 32'(busy_n), 32'd16);
  endtask

  initial begin
    logic [15:0] rc, ec;
    logic [5:0]  rf, ef, mflags;
    int lat, busy_n;
    bit ok, seen;

    vecs = '{
      '{16'h0050, 16'h7FFF, 16'h0001, 16'h8000, 6'h14},  // ADD signed overflow
      '{16'h0050, 16'hFFFF, 16'h0001, 16'h0000, 6'h09},  // ADD carry out, zero
      '{16'h0070, 16'h0000, 16'h0000, 16'h0001, 6'h00},  // ADDC uses previous carry
      '{16'h8040, 16'h0010, 16'hFFFE, 16'h0004, 6'h00},  // LSH by -2
      '{16'h8033, 16'h8000, 16'h0000, 16'hF000, 6'h10},  // ASHUI right 3
      '{16'h8040, 16'h0010, 16'h0010, 16'h0000, 6'h08},  // LSH by WIDTH
      '{16'hB001, 16'hFFFF, 16'h0000, 16'h0000, 6'h10},  // CMPI signed less
      '{16'hF000, 16'h1234, 16'h5678, 16'h0000, 6'h20},  // undefined major
      '{16'h00E0, 16'h0003, 16'h0005, 16'h000F, 6'h00},  // MUL small
      '{16'h00E0, 16'h0100, 16'h0100, 16'h0000, 6'h0C},  // MUL high half only
      '{16'h0090, 16'h0003, 16'h0005, 16'hFFFE, 6'h11},  // SUB borrow
      '{16'h9080, 16'h7FF0, 16'h0000, 16'h8070, 6'h15},  // SUBI -128 overflow
      '{16'h0010, 16'hF0F0, 16'h0FF0, 16'h00F0, 6'h00},  // AND
      '{16'h0030, 16'hAAAA, 16'hAAAA, 16'h0000, 6'h08},  // XOR zero
      '{16'h00B0, 16'h8000, 16'h0001, 16'h0000, 6'h10},  // CMP signed vs unsigned
      '{16'h8060, 16'h8000, 16'hFFE0, 16'hFFFF, 6'h10},  // ASHU right 32 sign-fill
      '{16'h800F, 16'h0003, 16'h0000, 16'h8000, 6'h10},  // LSHI left 15
      '{16'h0020, 16'h0000, 16'h0000, 16'h0000, 6'h08},  // OR zero
      '{16'h0040, 16'h0001, 16'h0001, 16'h0000, 6'h20},  // undefined ext
      '{16'h0050, 16'h8000, 16'h8000, 16'h0000, 6'h0D}   // ADD neg overflow to zero
    };

    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; OpCode = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_C", 32'(C), 32'd0);
    check("reset_Flags", 32'(Flags), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rc, rf, lat, busy_n, ok);
      if (ok) check_result($sformatf("vec%0d", i), vecs[i].op, rc, rf, lat, busy_n, vecs[i].c, vecs[i].f);
    end

    mflags = vecs[19].f;
    for (int n = 0; n < 250; n++) begin
      logic [15:0] op, a, b;
      op = pick_op();
      a = pick_val();
      b = pick_val();
      ref_op(op, a, b, mflags[0], ec, ef);
      run_op(op, a, b, rc, rf, lat, busy_n, ok);
      if (!ok) break;
      check_result($sformatf("rand%0d", n), op, rc, rf, lat, busy_n, ec, ef);
      mflags = ef;
    end

    // Backpressure: second op waits for the first to drain, then loads on that edge
    @(negedge CLK);
    out_ready = 1'b0;
    OpCode = 16'h0050; A = 16'h0001; B = 16'h0002; in_valid = 1'b1;
    check("bp_in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_C", 32'(C), 32'h0003);
    OpCode = 16'h0090; A = 16'h0001; B = 16'h0002;
    check("bp_in_ready_stalled", 32'(in_ready), 32'd0);
    repeat (3) @(negedge CLK);
    check("bp_C_stable", 32'(C), 32'h0003);
    check("bp_Flags_stable", 32'(Flags), 32'h00);
    check("bp_still_stalled", 32'(in_ready), 32'd0);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_drain", 32'(in_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_C", 32'(C), 32'hFFFF);
    check("bp_second_Flags", 32'(Flags), 32'h11);
    @(posedge CLK);
    @(negedge CLK);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_Flags_retained", 32'(Flags), 32'h11);

    // Reset in the middle of a multiply: no result may appear
    issue(16'h00E0, 16'h1234, 16'h0077, ok);
    check("mulrst_busy", 32'(busy), 32'd1);
    check("mulrst_in_ready_low", 32'(in_ready), 32'd0);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    check("mulrst_no_result", 32'(seen), 32'd0);
    check("mulrst_Flags", 32'(Flags), 32'd0);
    check("mulrst_C", 32'(C), 32'd0);
    check("mulrst_busy_clear", 32'(busy), 32'd0);
    check("mulrst_in_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
